// File: rtl/quire_to_posit.sv
// Converts a segmented two's-complement quire into a WIDTH-bit posit (es = EXP).
// The leading one is found one segment per cycle, then normalised, rounded and packed.
//
// state | meaning
// IDLE  | waiting for a rising edge of acc_rdy
// ABS   | sign and magnitude of the captured quire
// SCAN  | segment-serial leading-one search
// NORM  | left-align fraction, split scale into regime and exponent
// PACK  | build, round and clamp the posit word
// OUT   | result presented until out_rdy
module quire_to_posit #(
  parameter int WIDTH    = 8,
  parameter int K        = 9,
  parameter int EXP      = 2,
  parameter int ACC      = (2**EXP)*(WIDTH-2),
  parameter int ACC_HEAD = $clog2(K)+2
) (
  input  logic                clk_i,
  input  logic                rstn,
  input  logic                acc_rdy,
  input  logic [ACC_HEAD-1:0] acc_100_c,
  input  logic [ACC-1:0]      acc_000_c,
  input  logic [ACC-1:0]      acc_001_c,
  input  logic [ACC-1:0]      acc_010_c,
  input  logic [ACC-1:0]      acc_011_c,
  input  logic                out_rdy,
  output logic                out_vld,
  output logic [WIDTH-1:0]    posit_o,
  output logic                busy
);

  localparam int QW = ACC_HEAD + 4*ACC;
  localparam int LW = $clog2(QW);
  localparam int PW = $clog2(ACC);
  localparam int SW = LW + 1;
  localparam int V  = 2*WIDTH + EXP + 2;
  localparam logic signed [SW-1:0] K_MAX = SW'(WIDTH-2);
  localparam logic signed [SW-1:0] K_MIN = -K_MAX;

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_SCAN, S_NORM, S_PACK, S_OUT} state_t;

  state_t state, nxt;

  logic                 acc_rdy_q;
  logic [QW-1:0]        q_r;
  logic                 sign_r;
  logic [2:0]           seg_idx;
  logic                 done_r;
  logic                 zero_r;
  logic [LW-1:0]        lead_r;
  logic [WIDTH-1:0]     frac_r;
  logic                 sticky_r;
  logic signed [SW-1:0] k_r;
  logic [EXP-1:0]       e_r;

  logic                 capture;
  logic [ACC-1:0]       seg_val;
  logic [LW-1:0]        seg_base;
  logic [LW-1:0]        sh;
  logic [QW-2:0]        norm;
  logic signed [SW-1:0] scale;
  logic [SW-1:0]        shamt;
  logic [V-1:0]         start;
  logic signed [V-1:0]  start_s;
  logic [V-1:0]         vec;
  logic [WIDTH-2:0]     body;
  logic                 guard;
  logic                 rest;
  logic [WIDTH-1:0]     mag_sum;
  logic [WIDTH-1:0]     mag;
  logic [WIDTH-1:0]     pack_word;

  function automatic logic [PW-1:0] lead_pos(input logic [ACC-1:0] s);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < ACC; i++)
      if (s[i]) p = PW'(i);
    return p;
  endfunction

  assign capture = acc_rdy & ~acc_rdy_q;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    out_vld = 1'b0;
    busy    = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (capture) nxt = S_ABS;
      end
      S_ABS:  nxt = S_SCAN;
      S_SCAN: if (done_r) nxt = S_NORM;
      S_NORM: nxt = S_PACK;
      S_PACK: nxt = S_OUT;
      S_OUT: begin
        out_vld = 1'b1;
        if (out_rdy) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    seg_val  = '0;
    seg_base = '0;
    case (seg_idx)
      3'd0: begin
        seg_val  = {{(ACC-ACC_HEAD){1'b0}}, q_r[QW-1 -: ACC_HEAD]};
        seg_base = LW'(4*ACC);
      end
      3'd1: begin seg_val = q_r[4*ACC-1 -: ACC]; seg_base = LW'(3*ACC); end
      3'd2: begin seg_val = q_r[3*ACC-1 -: ACC]; seg_base = LW'(2*ACC); end
      3'd3: begin seg_val = q_r[2*ACC-1 -: ACC]; seg_base = LW'(ACC);   end
      default: begin seg_val = q_r[ACC-1:0]; seg_base = '0; end
    endcase
  end

  // Shifting without bit QW-1 drops the hidden one out of the top.
  assign sh    = LW'(QW-1) - lead_r;
  assign norm  = q_r[QW-2:0] << sh;
  assign scale = $signed({1'b0, lead_r}) - $signed(SW'(2*ACC));

  // Regime is produced by shifting a "10" (k>=0, sign-filled) or "01" (k<0) seed.
  always_comb begin
    shamt   = k_r[SW-1] ? ~k_r : k_r;
    start   = {(k_r[SW-1] ? 2'b01 : 2'b10), e_r, frac_r, {(V-EXP-WIDTH-2){1'b0}}};
    start_s = start;
    if (k_r[SW-1]) vec = start >> shamt;
    else           vec = start_s >>> shamt;
    body    = vec[V-1 -: WIDTH-1];
    guard   = vec[V-WIDTH];
    rest    = (|vec[V-WIDTH-1:0]) | sticky_r;
    mag_sum = {1'b0, body} + WIDTH'(guard & (rest | body[0]));
    if (k_r >= K_MAX || mag_sum[WIDTH-1])
      mag = {1'b0, {(WIDTH-1){1'b1}}};
    else if (k_r < K_MIN || mag_sum == '0)
      mag = WIDTH'(1);
    else
      mag = mag_sum;
    pack_word = zero_r ? '0 : (sign_r ? (~mag + WIDTH'(1)) : mag);
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      acc_rdy_q <= 1'b0;
      q_r       <= '0;
      sign_r    <= 1'b0;
      seg_idx   <= '0;
      done_r    <= 1'b0;
      zero_r    <= 1'b0;
      lead_r    <= '0;
      frac_r    <= '0;
      sticky_r  <= 1'b0;
      k_r       <= '0;
      e_r       <= '0;
      posit_o   <= '0;
    end else begin
      acc_rdy_q <= acc_rdy;
      case (state)
        S_IDLE: if (capture) begin
          q_r     <= {acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c};
          seg_idx <= '0;
          done_r  <= 1'b0;
          zero_r  <= 1'b0;
        end
        S_ABS: begin
          sign_r <= q_r[QW-1];
          q_r    <= q_r[QW-1] ? (~q_r + QW'(1)) : q_r;
        end
        // Detection and leading-one encoding are split over two cycles.
        S_SCAN: begin
          if (!done_r) begin
            if (seg_val != '0) begin
              done_r <= 1'b1;
            end else if (seg_idx == 3'd4) begin
              done_r <= 1'b1;
              zero_r <= 1'b1;
            end else begin
              seg_idx <= seg_idx + 3'd1;
            end
          end else begin
            lead_r <= seg_base + LW'(lead_pos(seg_val));
          end
        end
        S_NORM: begin
          frac_r   <= norm[QW-2 -: WIDTH];
          sticky_r <= |norm[QW-2-WIDTH:0];
          k_r      <= scale >>> EXP;
          e_r      <= scale[EXP-1:0];
        end
        S_PACK: posit_o <= pack_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quire_to_posit.sv
// Randomised scoreboard bench for quire_to_posit: expected posits come from a table of
// decoded 9-bit posits (floor code plus guard/sticky), checked by an independent monitor.
module tb_quire_to_posit;

  localparam int WIDTH = 8, K = 9, EXP = 2, ACC = 24, ACC_HEAD = 6;
  localparam int QW = ACC_HEAD + 4*ACC;

  logic                clk_i = 1'b0;
  logic                rstn = 1'b0;
  logic                acc_rdy = 1'b0;
  logic [ACC_HEAD-1:0] acc_100_c = '0;
  logic [ACC-1:0]      acc_000_c = '0, acc_001_c = '0, acc_010_c = '0, acc_011_c = '0;
  logic                out_rdy = 1'b1;
  logic                out_vld;
  logic [WIDTH-1:0]    posit_o;
  logic                busy;

  quire_to_posit #(.WIDTH(WIDTH), .K(K), .EXP(EXP)) dut (
    .clk_i(clk_i), .rstn(rstn), .acc_rdy(acc_rdy),
    .acc_100_c(acc_100_c), .acc_000_c(acc_000_c), .acc_001_c(acc_001_c),
    .acc_010_c(acc_010_c), .acc_011_c(acc_011_c),
    .out_rdy(out_rdy), .out_vld(out_vld), .posit_o(posit_o), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [7:0] p; int lat;} exp_t;
  exp_t         exp_q[$];
  int           cap_q[$];
  int           checks = 0, errors = 0, cyc = 0;
  int           bp_mode = 0;
  bit           hold_rdy = 1'b0;
  logic [127:0] val9 [256];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Exact value of the positive 9-bit posit with body bits c, in units of 2^-48.
  function automatic logic [127:0] p9_val(input logic [7:0] c);
    int i, run, k, e, m;
    logic r;
    logic [127:0] f;
    i = 7; run = 0; r = c[7];
    for (int j = 7; j >= 0; j--)
      if (i == j && c[j] == r) begin run++; i = j - 1; end
    k = r ? run - 1 : -run;
    i = i - 1;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((i >= 0) ? int'(c[3'(i)]) : 0);
      i = i - 1;
    end
    m = (i >= 0) ? i + 1 : 0;
    f = '0;
    for (int j = 0; j < 8; j++) if (j <= i) f[j] = c[j];
    return ((128'(1) << m) + f) << (48 + 4*k + e - m);
  endfunction

  function automatic logic [7:0] model(input logic [QW-1:0] q);
    logic [QW-1:0] a;
    logic [127:0]  x;
    logic [7:0]    c, t, mag;
    a = q[QW-1] ? -q : q;
    x = 128'(a);
    if (x == '0) return 8'h00;
    if (x >= (128'(1) << 72))      mag = 8'h7F;
    else if (x < (128'(1) << 24))  mag = 8'h01;
    else begin
      c = 8'd1;
      for (int j = 1; j < 256; j++) if (val9[j] <= x) c = 8'(j);
      t = c >> 1;
      mag = t + 8'((c[0] && ((x > val9[c]) || t[0])) ? 1 : 0);
      if (mag > 8'h7F) mag = 8'h7F;
      if (mag == 8'h00) mag = 8'h01;
    end
    return q[QW-1] ? 8'(-mag) : mag;
  endfunction

  function automatic int nseg(input logic [QW-1:0] q);
    logic [QW-1:0] a;
    a = q[QW-1] ? -q : q;
    if (a[QW-1 -: ACC_HEAD] != '0) return 1;
    for (int s = 0; s < 4; s++)
      if (a[(4-s)*ACC-1 -: ACC] != '0) return s + 2;
    return 5;
  endfunction

  function automatic logic [QW-1:0] mk(input logic [5:0] h, input logic [23:0] s1,
                                       input logic [23:0] s2, input logic [23:0] s3,
                                       input logic [23:0] s4);
    return {h, s1, s2, s3, s4};
  endfunction

  function automatic logic [QW-1:0] rand_q();
    logic [127:0]  r;
    logic [QW-1:0] q;
    int            top;
    r   = {$urandom(), $urandom(), $urandom(), $urandom()};
    top = $urandom_range(0, QW-2);
    q   = r[QW-1:0] & ({QW{1'b1}} >> (QW-1-top));
    q[top] = 1'b1;
    for (int s = 0; s < 4; s++)
      if ($urandom_range(0, 2) == 0) q[s*ACC +: ACC] = '0;
    if ($urandom_range(0, 1) == 1) q = -q;
    return q;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy && !out_vld && exp_q.size() == 0) return;
      @(posedge clk_i); #1;
    end
    checks++; errors++;
    $display("FAIL wait_idle: DUT still busy=%0b out_vld=%0b after 400 cycles", busy, out_vld);
  endtask

  task automatic issue(input logic [QW-1:0] q, input bit push);
    exp_t ev;
    wait_idle();
    @(posedge clk_i); #1;
    {acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c} = q;
    acc_rdy = 1'b1;
    if (push) begin
      ev.p = model(q);
      ev.lat = nseg(q) + 4;
      exp_q.push_back(ev);
      cap_q.push_back(cyc);
    end
    @(posedge clk_i); #1;
    if (!hold_rdy) acc_rdy = 1'b0;
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    case (bp_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  end

  logic [7:0] held_exp = '0;
  bit         prev_vld = 1'b0;

  always @(negedge clk_i) begin : monitor
    exp_t ev;
    int   c0;
    if (rstn) begin
      if (out_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got posit %02h with no conversion pending", posit_o);
        end else begin
          ev = exp_q.pop_front();
          c0 = cap_q.pop_front();
          check("posit_o", 128'(posit_o), 128'(ev.p));
          check("latency", 128'(cyc - c0 - 1), 128'(ev.lat));
          held_exp = ev.p;
        end
      end else if (out_vld && prev_vld) begin
        check("hold_posit", 128'(posit_o), 128'(held_exp));
      end
    end
    prev_vld = out_vld;
  end

  initial begin
    logic [QW-1:0] dir [10];
    int            waited;
    for (int j = 1; j < 256; j++) val9[j] = p9_val(8'(j));
    val9[0] = '0;

    dir[0] = mk(6'h00, 24'h0, 24'h1, 24'h0, 24'h0);             // 1.0 -> 40
    dir[1] = mk(6'h00, 24'h0, 24'h1, 24'h800000, 24'h0);        // 1.5 -> 44
    dir[2] = mk(6'h3F, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0);   // -1.0 -> C0
    dir[3] = '0;                                                // zero
    dir[4] = mk(6'h01, 24'h0, 24'h0, 24'h0, 24'h0);             // saturate -> 7F
    dir[5] = mk(6'h00, 24'h0, 24'h0, 24'h0, 24'h1);             // underflow -> 01
    dir[6] = '1;                                                // Q=-1 -> FF
    dir[7] = mk(6'h00, 24'h0, 24'h1, 24'h100000, 24'h0);        // tie, even stays
    dir[8] = mk(6'h00, 24'h0, 24'h1, 24'h300000, 24'h0);        // tie, odd rounds up
    dir[9] = mk(6'h20, 24'h0, 24'h0, 24'h0, 24'h0);             // most negative

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_out_vld", 128'(out_vld), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_posit", 128'(posit_o), 128'(0));
    rstn = 1'b1;

    check("model_1p0", 128'(model(dir[0])), 128'(8'h40));
    check("model_1p5", 128'(model(dir[1])), 128'(8'h44));
    check("model_m1p0", 128'(model(dir[2])), 128'(8'hC0));

    for (int i = 0; i < 10; i++) issue(dir[i], 1'b1);

    bp_mode = 1;
    for (int i = 0; i < 150; i++) issue(rand_q(), 1'b1);
    wait_idle();
    bp_mode = 0;

    // Backpressure: out_rdy low for 20 cycles while OUT is held.
    bp_mode = 2;
    issue(dir[1], 1'b1);
    waited = 0;
    while (!out_vld && waited < 50) begin @(posedge clk_i); #1; waited++; end
    check("bp_reached_out", 128'(out_vld), 128'(1));
    repeat (20) @(posedge clk_i);
    #1;
    check("bp_out_vld", 128'(out_vld), 128'(1));
    check("bp_posit", 128'(posit_o), 128'(8'h44));
    bp_mode = 0;
    wait_idle();

    // acc_rdy held high: exactly one conversion.
    hold_rdy = 1'b1;
    issue(dir[0], 1'b1);
    wait_idle();
    repeat (30) @(posedge clk_i);
    #1;
    check("held_rdy_no_retrigger", 128'(busy), 128'(0));
    acc_rdy  = 1'b0;
    hold_rdy = 1'b0;

    // Reset during SCAN.
    issue(dir[0], 1'b0);
    @(posedge clk_i); #1;
    check("pre_reset_busy", 128'(busy), 128'(1));
    rstn = 1'b0;
    #1;
    check("rst_out_vld", 128'(out_vld), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_posit", 128'(posit_o), 128'(0));
    repeat (2) @(posedge clk_i);
    #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("post_reset_idle", 128'(busy), 128'(0));

    issue(dir[8], 1'b1);
    wait_idle();
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quire_to_posit.md
Name: quire_to_posit

Overview:
- Reads the segmented two's-complement accumulator produced by the posit MAC accumulate stage once its `acc_rdy` goes high.
- Normalises the value and rounds it, then encodes a WIDTH-bit posit with es = EXP.
- This is the output end of the accumulate interface: it consumes `acc_100_c` / `acc_000_c` .. `acc_011_c` and emits one posit per accumulation, under a valid/ready handshake.
- Multi-cycle: captures, takes the absolute value, scans segments for the leading one, shifts, then rounds and packs.

Parameters:
- WIDTH, 8, posit width in bits.
- K, 9, products per accumulation; sets the head width only.
- EXP, 2, posit exponent field width (es).
- ACC, (2**EXP)*(WIDTH-2), bits per accumulator segment.
- ACC_HEAD, $clog2(K)+2, accumulator head width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- acc_rdy  in  1  accumulator result valid (level).
- acc_100_c  in  ACC_HEAD  most significant segment, holds the sign.
- acc_000_c  in  ACC  segment 1.
- acc_001_c  in  ACC  segment 2.
- acc_010_c  in  ACC  segment 3.
- acc_011_c  in  ACC  segment 4, least significant.
- out_rdy  in  1  downstream accepts posit_o.
- out_vld  out  1  posit_o valid.
- posit_o  out  WIDTH  encoded posit result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Numeric format
  - Q = {acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c}, total ACC_HEAD+4*ACC bits, two's complement.
  - Value = Q * 2^-(2*ACC); the binary point sits between acc_001_c and acc_010_c.
- Reset: asynchronous, active-low. State goes to IDLE; out_vld=0, posit_o=0, busy=0; all internal registers cleared. Applies at any point, including mid-conversion. No partial result is emitted after reset.
- Capture
  - In IDLE, a rising edge of acc_rdy (acc_rdy=1 now, 0 on the previous cycle) latches all five segments and moves to ABS. Call this capturing edge E0.
  - A held-high acc_rdy never retriggers.
  - A rising edge outside IDLE is ignored.
  - acc_rdy falling after capture has no effect.
- States
  - IDLE → ABS: on capture, as above.
  - ABS (1 cycle): store sign = MSB of Q and magnitude M = |Q| (unsigned, same width). The most negative Q must not overflow. → SCAN.
  - SCAN: examine one segment of M per cycle, head first. Stop at the first nonzero segment and record its index and that segment's leading-one position. n = segments examined (1..5). If all five are zero, set the zero flag. → NORM.
  - NORM (1 cycle):
    - scale = (bit index of the leading one of M) - 2*ACC.
    - Left-align M so the hidden bit is dropped; keep WIDTH fraction bits plus a sticky OR of all remaining bits.
    - k = floor(scale / 2^EXP); e = scale mod 2^EXP.
    - → PACK.
  - PACK (1 cycle):
    - Build regime (k≥0: k+1 ones then a zero; k<0: -k zeros then a one), then e, then fraction. Truncate to WIDTH-1 bits with guard and sticky.
    - Round to nearest, ties to even.
    - Clamp the magnitude to [minpos = 1, maxpos = 2^(WIDTH-1)-1]: never round a nonzero value to 0 or to NaR. |scale| beyond the regime range saturates.
    - If sign=1, posit_o = two's complement of the magnitude word. Zero flag gives posit_o = 0.
    - → OUT.
  - OUT: out_vld=1 and posit_o is stable. When out_vld & out_rdy, the next state is IDLE, out_vld drops, and posit_o holds its last value.
- Latency: out_vld rises at the edge that is n+4 rising edges after E0. Zero input takes n=5, i.e. 9 edges.
- Backpressure: out_rdy low holds OUT indefinitely with posit_o unchanged. The earliest next capture is the cycle after the handshake.
- NaR (1 followed by zeros) is never produced.

Test Plan:
- Value 1.0: acc_001_c=1, all other segments 0, acc_rdy rising → posit_o=8'h40; out_vld high 7 edges after capture (n=3).
- Value 1.5: acc_001_c=1, acc_010_c=24'h800000 → posit_o=8'h44.
- Value -1.0: acc_100_c=6'h3F, acc_000_c=24'hFFFFFF, acc_001_c=24'hFFFFFF, others 0 → posit_o=8'hC0.
- Zero input → posit_o=8'h00, out_vld 9 edges after capture.
- Saturation: acc_100_c=6'h01, others 0 → 8'h7F. Underflow: only acc_011_c=1 → 8'h01, never 0. The acc_011_c=1 pattern with negation applied (Q = -1) → 8'hFF.
- Control:
  - Hold out_rdy=0 for 20 cycles: posit_o and out_vld stay constant.
  - Keep acc_rdy high throughout: there is no second conversion.
  - Assert rstn=0 during SCAN: out_vld=0 and busy=0 immediately, and no output appears after release.
